// File: rtl/axi_riscv_atomics_key_ctrl.sv
// axi_riscv_atomics_key_ctrl: stages a new atomics key and swaps it once all AW/AR traffic has drained
module axi_riscv_atomics_key_ctrl #(
    parameter int unsigned  MAX_TXNS  = 8,
    parameter logic [127:0] KEY_RESET = '0
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         cfg_we_i,
    input  logic [1:0]   cfg_idx_i,
    input  logic [31:0]  cfg_wdata_i,
    input  logic         cfg_commit_i,
    output logic         cfg_ready_o,
    output logic         done_o,
    output logic [127:0] key_o,
    input  logic         up_aw_valid_i,
    output logic         dn_aw_valid_o,
    input  logic         dn_aw_ready_i,
    output logic         up_aw_ready_o,
    input  logic         up_ar_valid_i,
    output logic         dn_ar_valid_o,
    input  logic         dn_ar_ready_i,
    output logic         up_ar_ready_o,
    input  logic         b_valid_i,
    input  logic         b_ready_i,
    input  logic         r_valid_i,
    input  logic         r_ready_i,
    input  logic         r_last_i
);
    localparam int unsigned CW = $clog2(MAX_TXNS + 1);
    typedef enum logic [1:0] {IDLE, DRAIN, SWAP} state_e;
    state_e           state, state_nxt;
    logic [CW-1:0]    wcnt, rcnt;
    logic [3:0][31:0] shadow;
    logic             aw_pend, ar_pend, blk_aw, blk_ar;
    logic             aw_hs, ar_hs, b_hs, r_hs, drained;
    // A valid already shown downstream stays up even while blocking
    assign blk_aw        = (state != IDLE || wcnt == CW'(MAX_TXNS)) && !aw_pend;
    assign blk_ar        = (state != IDLE || rcnt == CW'(MAX_TXNS)) && !ar_pend;
    assign dn_aw_valid_o = up_aw_valid_i && !blk_aw;
    assign up_aw_ready_o = dn_aw_ready_i && !blk_aw;
    assign dn_ar_valid_o = up_ar_valid_i && !blk_ar;
    assign up_ar_ready_o = dn_ar_ready_i && !blk_ar;
    assign aw_hs         = dn_aw_valid_o && dn_aw_ready_i;
    assign ar_hs         = dn_ar_valid_o && dn_ar_ready_i;
    assign b_hs          = b_valid_i && b_ready_i;
    assign r_hs          = r_valid_i && r_ready_i && r_last_i;
    assign drained       = wcnt == '0 && rcnt == '0 && !aw_pend && !ar_pend;
    always_ff @(posedge clk_i) begin
        if (!rst_ni) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt = (state == IDLE && cfg_commit_i) ? DRAIN :
                    (state == DRAIN && drained)     ? SWAP  :
                    (state == SWAP)                 ? IDLE  : state;
    end
    always_comb begin
        cfg_ready_o = state == IDLE;
        done_o      = state == SWAP;
    end
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            key_o   <= KEY_RESET;
            shadow  <= '0;
            wcnt    <= '0;
            rcnt    <= '0;
            aw_pend <= 1'b0;
            ar_pend <= 1'b0;
        end else begin
            if (state == IDLE && cfg_we_i) shadow[cfg_idx_i] <= cfg_wdata_i;
            if (state == SWAP) key_o <= shadow;
            wcnt    <= wcnt + CW'(aw_hs && !b_hs) - CW'(b_hs && !aw_hs);
            rcnt    <= rcnt + CW'(ar_hs && !r_hs) - CW'(r_hs && !ar_hs);
            aw_pend <= dn_aw_valid_o && !dn_aw_ready_i;
            ar_pend <= dn_ar_valid_o && !dn_ar_ready_i;
        end
    end
    always_ff @(posedge clk_i) begin
        if (rst_ni) assert (!(b_hs && !aw_hs && wcnt == '0) && !(r_hs && !ar_hs && rcnt == '0));
    end
endmodule
